alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor of the single-cycle RV32 ALU.
- Executes ADD/SUB/AND/OR/XOR/SLT/SLTU in one registered cycle.
- Adds iterative unsigned MUL/MULHU and DIVU/REMU (RV32M subset) over XLEN cycles.
- Sits between decode and writeback in the multi-cycle core; stalls the pipeline via valid/ready.

Parameters:
- XLEN, 32: operand/result width; must be ≥ 4.
- CW, $clog2(XLEN)+1: iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept (high only in IDLE).
- A  in  XLEN  operand A.
- B  in  XLEN  operand B.
- ALUControl  in  4  op code (see Behaviour).
- out_valid  out  1  Result/flags valid.
- out_ready  in  1  consumer accepts result.
- Result  out  XLEN  registered result.
- Z  out  1  registered zero flag.
- N  out  1  registered negative flag.
- V  out  1  registered signed-overflow flag.
- C  out  1  registered carry flag.
- busy  out  1  high in MUL or DIV state.

Behaviour:
- Op codes:
  - 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR; 0101 SLT (signed); 0111 SLTU.
  - 1000 MUL (low XLEN of A*B); 1001 MULHU (high XLEN, unsigned).
  - 1100 DIVU; 1101 REMU.
  - Any other code: Result=0, simple-op latency.
- Reset (rst==0 at posedge):
  - state=IDLE; in_ready=1 after reset; out_valid=0.
  - Result=0, Z=1, N=0, V=0, C=0, busy=0; counter and internal registers cleared.
  - Reset overrides everything, including mid-iteration; any in-flight op is discarded with no output.
- States: IDLE, MUL, DIV, DONE.
- Acceptance: in IDLE, in_valid=1 accepts the op; A, B, ALUControl are captured that edge.
- Simple ops: IDLE→DONE. Result/flags are registered at the accept edge, so out_valid=1 the following cycle (latency 1).
- Add/sub:
  - sum = A + (op[0] ? ~B : B) + op[0], XLEN+1 bits; C = carry-out.
  - V = ~(op[0]^A[msb]^B[msb]) & (A[msb]^sum[msb]).
  - For non-add/sub ops, V=C=0.
- SLT: Result = {0…, sum[msb]^V}, so the signed compare stays correct on overflow.
- SLTU: Result = {0…, ~C} of A−B.
- Z = (Result==0); N = Result[msb] for all ops.
- MUL/MULHU:
  - IDLE→MUL; shift-add over a 2·XLEN product register, one bit per cycle, counter from XLEN down to 0.
  - At count 0 → DONE with Result = low or high half.
- DIVU/REMU:
  - IDLE→DIV; restoring division, one quotient bit per cycle, XLEN cycles → DONE.
- Iterative latency: accept at edge t; out_valid high at edge t+XLEN+1 (XLEN iteration cycles plus one DONE-load edge). Fixed, data-independent.
- Divide by zero (B==0): quotient = all ones, remainder = A (RISC-V rule). Still takes the full XLEN cycles; no trap.
- Flags for MUL/DIV ops: Z, N from Result; V=C=0.
- DONE:
  - out_valid=1; Result/flags held stable until out_ready=1.
  - On out_ready → IDLE.
  - in_ready is low in DONE, so there is no same-cycle accept; throughput is one op per ≥2 cycles.
- in_valid while not IDLE is ignored; A, B and ALUControl changes outside IDLE have no effect.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Reset: hold rst=0 for 2 cycles during a DIVU in flight → out_valid=0, Result=0, Z=1, in_ready=1; next op executes correctly.
- ADD overflow, XLEN=32: A=0x7FFFFFFF, B=1, op 0000 → next cycle Result=0x80000000, N=1, V=1, C=0, Z=0.
- SUB/SLT: A=5, B=5, op 0001 → Result=0, Z=1, C=1. Then A=0x80000000, B=1, op 0101 → Result=1 (overflow-corrected).
- MUL/MULHU: A=0xFFFFFFFF, B=2.
  - op 1000 → Result=0xFFFFFFFE.
  - op 1001 → Result=1.
  - out_valid first high exactly 33 cycles after accept; busy high during iteration.
- DIVU by zero and REMU: A=100, B=0, op 1100 → Result=0xFFFFFFFF. A=100, B=7, op 1101 → Result=2.
- Backpressure: out_ready=0 for 5 cycles in DONE → Result/flags stable, in_ready=0, new in_valid ignored. out_ready=1 → IDLE next cycle, then the new op is accepted.

Source files
------------

// File: rtl/alu_seq_if.sv
// Handshaked operand/result bus between decode, the sequential ALU and writeback.
// slave is the ALU side; master is the producer/consumer side.
interface alu_seq_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] A;
   logic [XLEN-1:0] B;
   logic [3:0]      ALUControl;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] Result;
   logic            Z;
   logic            N;
   logic            V;
   logic            C;
   logic            busy;

   modport slave (
      input  in_valid, A, B, ALUControl, out_ready,
      output in_ready, out_valid, Result, Z, N, V, C, busy
   );

   modport master (
      output in_valid, A, B, ALUControl, out_ready,
      input  in_ready, out_valid, Result, Z, N, V, C, busy
   );
endinterface

// File: rtl/alu_seq.sv
// Sequential RV32 ALU: single-cycle logic/arith ops plus iterative unsigned
// MUL/MULHU and DIVU/REMU with a fixed XLEN+1 edge latency.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | in_ready high, waiting for in_valid
// MUL    | shift-add multiply, one multiplier bit per cycle
// DIV    | restoring divide, one quotient bit per cycle
// DONE   | out_valid high, Result/flags held until out_ready
module alu_seq #(
   parameter int XLEN = 32
) (
   input  logic       clk,
   input  logic       rst,
   alu_seq_if.slave   bus
);
   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            sel_hi_q, sel_hi_d;
   logic [XLEN-1:0] opnd_q, opnd_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            z_q, z_d;
   logic            n_q, n_d;
   logic            v_q, v_d;
   logic            c_q, c_d;

   logic [3:0]      op_in;
   logic [XLEN-1:0] b_eff;
   logic [XLEN:0]   sum;
   logic            ovf;
   logic [XLEN-1:0] simple_res;
   logic            simple_v;
   logic            simple_c;

   logic [XLEN:0]   mul_add;
   logic [XLEN:0]   div_shift;
   logic [XLEN-1:0] div_diff;
   logic            div_ge;
   logic [XLEN-1:0] fin_res;

   assign op_in = bus.ALUControl;

   // Shared adder: SUB, SLT and SLTU all subtract since op[0] is set for each.
   always_comb begin
      b_eff      = op_in[0] ? ~bus.B : bus.B;
      sum        = {1'b0, bus.A} + {1'b0, b_eff} + {{XLEN{1'b0}}, op_in[0]};
      ovf        = ~(op_in[0] ^ bus.A[XLEN-1] ^ bus.B[XLEN-1])
                   & (bus.A[XLEN-1] ^ sum[XLEN-1]);
      simple_res = '0;
      simple_v   = 1'b0;
      simple_c   = 1'b0;
      case (op_in)
         4'b0000, 4'b0001: begin
            simple_res = sum[XLEN-1:0];
            simple_v   = ovf;
            simple_c   = sum[XLEN];
         end
         4'b0010: simple_res = bus.A & bus.B;
         4'b0011: simple_res = bus.A | bus.B;
         4'b0100: simple_res = bus.A ^ bus.B;
         4'b0101: simple_res[0] = sum[XLEN-1] ^ ovf;
         4'b0111: simple_res[0] = ~sum[XLEN];
         default: simple_res = '0;
      endcase
   end

   // hi/lo hold product {upper, lower} for MUL and {remainder, quotient} for DIV,
   // so the selected half at the end maps identically for MULHU and REMU.
   always_comb begin
      mul_add   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
      div_shift = {hi_q, lo_q[XLEN-1]};
      div_ge    = (div_shift >= {1'b0, opnd_q});
      div_diff  = div_shift[XLEN-1:0] - opnd_q;
      fin_res   = sel_hi_q ? hi_q : lo_q;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sel_hi_d = sel_hi_q;
      opnd_d   = opnd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      result_d = result_q;
      z_d      = z_q;
      n_d      = n_q;
      v_d      = v_q;
      c_d      = c_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               sel_hi_d = op_in[0];
               if (op_in[3:1] == 3'b100) begin
                  opnd_d  = bus.A;
                  hi_d    = '0;
                  lo_d    = bus.B;
                  cnt_d   = CW'(XLEN);
                  state_d = S_MUL;
               end else if (op_in[3:1] == 3'b110) begin
                  opnd_d  = bus.B;
                  hi_d    = '0;
                  lo_d    = bus.A;
                  cnt_d   = CW'(XLEN);
                  state_d = S_DIV;
               end else begin
                  result_d = simple_res;
                  z_d      = (simple_res == '0);
                  n_d      = simple_res[XLEN-1];
                  v_d      = simple_v;
                  c_d      = simple_c;
                  state_d  = S_DONE;
               end
            end
         end
         S_MUL, S_DIV: begin
            if (cnt_q == '0) begin
               result_d = fin_res;
               z_d      = (fin_res == '0);
               n_d      = fin_res[XLEN-1];
               v_d      = 1'b0;
               c_d      = 1'b0;
               state_d  = S_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
               if (state_q == S_MUL) begin
                  hi_d = mul_add[XLEN:1];
                  lo_d = {mul_add[0], lo_q[XLEN-1:1]};
               end else begin
                  hi_d = div_ge ? div_diff : div_shift[XLEN-1:0];
                  lo_d = {lo_q[XLEN-2:0], div_ge};
               end
            end
         end
         S_DONE: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         sel_hi_q <= 1'b0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
         z_q      <= 1'b1;
         n_q      <= 1'b0;
         v_q      <= 1'b0;
         c_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sel_hi_q <= sel_hi_d;
         opnd_q   <= opnd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         result_q <= result_d;
         z_q      <= z_d;
         n_q      <= n_d;
         v_q      <= v_d;
         c_q      <= c_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.busy      = (state_q == S_MUL) || (state_q == S_DIV);
   assign bus.Result    = result_q;
   assign bus.Z         = z_q;
   assign bus.N         = n_q;
   assign bus.V         = v_q;
   assign bus.C         = c_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, random ops against an arithmetic
// reference model, and hand sequences for reset, latency and backpressure.
module tb_alu_seq;
   localparam int XLEN = 32;
   localparam int ITER_LAT = XLEN + 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   alu_seq_if #(.XLEN(XLEN)) bus ();
   alu_seq #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      logic        n;
      logic        v;
      logic        c;
   } vec_t;

   vec_t       tbl[13];
   logic [3:0] ops[14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit is_iter(input logic [3:0] op);
      return (op == 4'h8) || (op == 4'h9) || (op == 4'hC) || (op == 4'hD);
   endfunction

   // Reference: plain integer arithmetic on the ISA-level definition of each op.
   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic v, output logic c);
      longint sa, sb, s;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = 64'(a) * 64'(b);
      r = '0; v = 1'b0; c = 1'b0;
      case (op)
         4'h0: begin
            r = a + b;
            s = sa + sb;
            c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
            v = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
         end
         4'h1: begin
            r = a - b;
            s = sa - sb;
            c = (a >= b);
            v = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
         end
         4'h2: r = a & b;
         4'h3: r = a | b;
         4'h4: r = a ^ b;
         4'h5: r = (sa < sb) ? 32'd1 : 32'd0;
         4'h7: r = (a < b) ? 32'd1 : 32'd0;
         4'h8: r = p[31:0];
         4'h9: r = p[63:32];
         4'hC: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         4'hD: r = (b == 0) ? a : a % b;
         default: r = '0;
      endcase
   endfunction

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic z, output logic n,
                         output logic v, output logic c, output int lat, output int busy_bad);
      @(negedge clk);
      check("in_ready_before_accept", bus.in_ready, 1);
      bus.in_valid   = 1'b1;
      bus.A          = a;
      bus.B          = b;
      bus.ALUControl = op;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 0;
      busy_bad = 0;
      while (!bus.out_valid && lat < 100) begin
         if (!bus.busy) busy_bad++;
         @(posedge clk);
         #1;
         lat++;
      end
      r = bus.Result; z = bus.Z; n = bus.N; v = bus.V; c = bus.C;
      check("busy_low_in_done", bus.busy, 0);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("idle_after_out_ready", {bus.in_ready, bus.out_valid}, 2'b10);
   endtask

   task automatic apply_and_check(input string tag, input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] er, input logic ez,
                                  input logic en, input logic ev, input logic ec);
      logic [31:0] r;
      logic z, n, v, c;
      int lat, busy_bad;
      run_op(op, a, b, r, z, n, v, c, lat, busy_bad);
      check({tag, "_result"}, r, er);
      check({tag, "_flags_znvc"}, {z, n, v, c}, {ez, en, ev, ec});
      check({tag, "_latency"}, lat, is_iter(op) ? ITER_LAT : 0);
      check({tag, "_busy_while_iter"}, busy_bad, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] er, a, b, r;
      logic ev, ec, z, n, v, c, z0, n0, v0, c0;
      logic [3:0] op;
      int ov_seen;

      tbl[0]  = '{4'h0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[1]  = '{4'h1, 32'd5,         32'd5,         32'h0,         1'b1, 1'b0, 1'b0, 1'b1};
      tbl[2]  = '{4'h5, 32'h8000_0000, 32'h1,         32'h1,         1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{4'h8, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{4'h9, 32'hFFFF_FFFF, 32'h2,         32'h1,         1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{4'hC, 32'd100,       32'd0,         32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{4'hD, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{4'h7, 32'd3,         32'd5,         32'd1,         1'b0, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{4'h4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{4'h6, 32'd5,         32'd5,         32'h0,         1'b1, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{4'h1, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[11] = '{4'hC, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{4'h0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0, 1'b0, 1'b1};

      ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8,
              4'h9, 4'hC, 4'hD, 4'h6, 4'hA, 4'hF};

      bus.in_valid = 1'b0;
      bus.A = '0;
      bus.B = '0;
      bus.ALUControl = '0;
      bus.out_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("reset_ready_valid", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
      check("reset_result", bus.Result, 0);
      check("reset_flags_znvc", {bus.Z, bus.N, bus.V, bus.C}, 4'b1000);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 13; i++)
         apply_and_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                         tbl[i].res, tbl[i].z, tbl[i].n, tbl[i].v, tbl[i].c);

      for (int i = 0; i < 40; i++) begin
         op = ops[$urandom_range(0, 13)];
         a  = $urandom();
         b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
         model(op, a, b, er, ev, ec);
         apply_and_check($sformatf("rnd%0d_op%0h", i, op), op, a, b,
                         er, er == 0, er[31], ev, ec);
      end

      // Reset in the middle of a DIVU must discard it entirely.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.A = 32'd100;
      bus.B = 32'd7;
      bus.ALUControl = 4'hC;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("midrst_ready_valid_busy", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
      check("midrst_result", bus.Result, 0);
      check("midrst_z", bus.Z, 1);
      @(negedge clk);
      rst = 1'b1;
      ov_seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) ov_seen++;
      end
      check("midrst_no_stale_output", ov_seen, 0);
      apply_and_check("after_rst_remu", 4'hD, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);

      // Backpressure: result held while out_ready low; new op ignored until IDLE.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.A = 32'd3;
      bus.B = 32'd4;
      bus.ALUControl = 4'h0;
      @(posedge clk);
      #1;
      check("bp_first_valid", bus.out_valid, 1);
      check("bp_first_result", bus.Result, 7);
      z0 = bus.Z; n0 = bus.N; v0 = bus.V; c0 = bus.C;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.A = 32'd10;
         bus.B = 32'd20;
         bus.ALUControl = 4'h1;
         @(posedge clk);
         #1;
         check($sformatf("bp_hold%0d_valid_ready", i), {bus.out_valid, bus.in_ready}, 2'b10);
         check($sformatf("bp_hold%0d_result", i), bus.Result, 7);
         check($sformatf("bp_hold%0d_flags", i), {bus.Z, bus.N, bus.V, bus.C}, {z0, n0, v0, c0});
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_idle", {bus.in_ready, bus.out_valid}, 2'b10);
      @(negedge clk);
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      model(4'h1, 32'd10, 32'd20, er, ev, ec);
      check("bp_new_valid", bus.out_valid, 1);
      check("bp_new_result", bus.Result, er);
      check("bp_new_flags", {bus.Z, bus.N, bus.V, bus.C}, {er == 0, er[31], ev, ec});
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("bp_final_idle", {bus.in_ready, bus.out_valid}, 2'b10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
